// File: rtl/router_arb_pkg.sv
// Shared types and helpers for the wormhole output arbiter.
// Holds the arbiter FSM state encoding and a width helper used by its index ports.
package router_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Index width that never collapses to zero bits for tiny port counts.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating-priority search: the first set request at or above ptr, wrapping around.
// Purely combinational; returns a one-hot grant, its index and a valid flag.
module rr_priority_picker
    import router_arb_pkg::*;
#(
    parameter int NUM_INPUTS = 5,
    parameter int IW         = clog2_min1(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req_vec,
    input  logic [IW-1:0]         ptr,
    output logic [NUM_INPUTS-1:0] grant_onehot,
    output logic [IW-1:0]         grant_index,
    output logic                  grant_valid
);

    logic [IW-1:0] idx;

    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    always_comb begin
        grant_onehot = '0;
        grant_index  = '0;
        grant_valid  = 1'b0;
        idx          = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            idx = IW'((int'(ptr) + k) % NUM_INPUTS);
            if (!grant_valid && req_vec[idx]) begin
                grant_valid       = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_index       = idx;
            end
        end
    end

endmodule

// File: rtl/wormhole_output_arbiter.sv
// Wormhole output-port arbiter: round-robin packet grants, lock until tail, credit flow control.
// Optional turn masking is enabled by defining ROUTER_ARB_TURN_MASK_EN.
module wormhole_output_arbiter
    import router_arb_pkg::*;
#(
    parameter  int NUM_INPUTS        = 5,
    parameter  int FLIT_BUFFER_DEPTH = 2,
    localparam int CW                = $clog2(FLIT_BUFFER_DEPTH + 1),
    localparam int IW                = clog2_min1(NUM_INPUTS)
) (
    input  logic                  clk_noc,
    input  logic                  rst_noc_sync,
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [NUM_INPUTS-1:0] req_is_tail,
    input  logic [NUM_INPUTS-1:0] disable_mask,
    input  logic                  credit_in,
    output logic [NUM_INPUTS-1:0] grant,
    output logic                  send_out,
    output logic                  locked,
    output logic [IW-1:0]         lock_owner,
    output logic [CW-1:0]         credit_count,
    output logic                  credit_overflow
);

    arb_state_e            state_q, state_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]         lock_owner_q, lock_owner_d;
    logic [CW-1:0]         credit_q, credit_d;
    logic                  overflow_q, overflow_d;

    logic [NUM_INPUTS-1:0] eff_mask;
    logic [NUM_INPUTS-1:0] pick_grant;
    logic [IW-1:0]         pick_index;
    logic                  pick_valid;
    logic [NUM_INPUTS-1:0] grant_c;
    logic [IW-1:0]         sel_idx;
    logic                  send_c;

`ifdef ROUTER_ARB_TURN_MASK_EN
    assign eff_mask = disable_mask;
`else
    logic unused_disable_mask;
    assign unused_disable_mask = ^disable_mask;
    assign eff_mask            = '0;
`endif

    rr_priority_picker #(
        .NUM_INPUTS (NUM_INPUTS),
        .IW         (IW)
    ) u_picker (
        .req_vec      (req & ~eff_mask),
        .ptr          (rr_ptr_q),
        .grant_onehot (pick_grant),
        .grant_index  (pick_index),
        .grant_valid  (pick_valid)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_owner_d = lock_owner_q;
        credit_d     = credit_q;
        overflow_d   = overflow_q;
        grant_c      = '0;
        sel_idx      = (state_q == LOCKED) ? lock_owner_q : pick_index;

        // Only the registered count gates a grant; a credit arriving now is usable next cycle.
        if (!rst_noc_sync && credit_q != '0) begin
            if (state_q == IDLE) begin
                if (pick_valid) grant_c = pick_grant;
            end else if (req[lock_owner_q]) begin
                grant_c[lock_owner_q] = 1'b1;
            end
        end
        send_c = |grant_c;

        if (send_c) begin
            if (req_is_tail[sel_idx]) begin
                state_d  = IDLE;
                rr_ptr_d = (sel_idx == IW'(NUM_INPUTS - 1)) ? '0 : sel_idx + IW'(1);
            end else begin
                state_d      = LOCKED;
                lock_owner_d = sel_idx;
            end
        end

        case ({send_c, credit_in})
            2'b10: credit_d = credit_q - CW'(1);
            2'b01: begin
                if (credit_q == CW'(FLIT_BUFFER_DEPTH)) overflow_d = 1'b1;
                else                                    credit_d   = credit_q + CW'(1);
            end
            default: credit_d = credit_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            lock_owner_q <= '0;
            credit_q     <= CW'(FLIT_BUFFER_DEPTH);
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_owner_q <= lock_owner_d;
            credit_q     <= credit_d;
            overflow_q   <= overflow_d;
        end
    end

    assign grant           = grant_c;
    assign send_out        = send_c;
    assign locked          = (state_q == LOCKED);
    assign lock_owner      = lock_owner_q;
    assign credit_count    = credit_q;
    assign credit_overflow = overflow_q;

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// Directed scoreboard bench for wormhole_output_arbiter (NUM_INPUTS=5, FLIT_BUFFER_DEPTH=2).
// Expected results are queued as each cycle is driven and popped when outputs are sampled.
module tb_wormhole_output_arbiter;

`ifdef ROUTER_ARB_TURN_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic       clk_noc = 1'b0;
    logic       rst_noc_sync;
    logic [4:0] req, req_is_tail, disable_mask;
    logic       credit_in;
    logic [4:0] grant;
    logic       send_out, locked, credit_overflow;
    logic [2:0] lock_owner;
    logic [1:0] credit_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] grant;
        logic       locked;
        bit         chk_owner;
        logic [2:0] owner;
        logic [1:0] count;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    wormhole_output_arbiter dut (
        .clk_noc         (clk_noc),
        .rst_noc_sync    (rst_noc_sync),
        .req             (req),
        .req_is_tail     (req_is_tail),
        .disable_mask    (disable_mask),
        .credit_in       (credit_in),
        .grant           (grant),
        .send_out        (send_out),
        .locked          (locked),
        .lock_owner      (lock_owner),
        .credit_count    (credit_count),
        .credit_overflow (credit_overflow)
    );

    always #5 clk_noc = ~clk_noc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check the combinational grant before the edge and the state after it.
    task automatic cycle(input string tag, input logic rst, input logic [4:0] r, input logic [4:0] t,
                         input logic [4:0] m, input logic ci, input logic [4:0] e_grant,
                         input logic e_locked, input bit e_chk_owner, input logic [2:0] e_owner,
                         input logic [1:0] e_count, input logic e_ovf);
        exp_t e;
        @(negedge clk_noc);
        rst_noc_sync = rst;
        req          = r;
        req_is_tail  = t;
        disable_mask = m;
        credit_in    = ci;
        sb.push_back('{e_grant, e_locked, e_chk_owner, e_owner, e_count, e_ovf});
        #2;
        e = sb.pop_front();
        check({tag, ".grant"}, 32'(grant), 32'(e.grant));
        check({tag, ".send_out"}, 32'(send_out), 32'(|e.grant));
        @(posedge clk_noc);
        #1;
        check({tag, ".locked"}, 32'(locked), 32'(e.locked));
        if (e.chk_owner) check({tag, ".lock_owner"}, 32'(lock_owner), 32'(e.owner));
        check({tag, ".credit_count"}, 32'(credit_count), 32'(e.count));
        check({tag, ".credit_overflow"}, 32'(credit_overflow), 32'(e.ovf));
    endtask

    initial begin
        rst_noc_sync = 1'b1;
        req          = '0;
        req_is_tail  = '0;
        disable_mask = '0;
        credit_in    = 1'b0;

        // Reset with requests present: no grant, reset state afterwards.
        cycle("reset",     1, 5'b11111, 5'b00000, 5'b00000, 0, 5'b00000, 0, 1, 3'd0, 2'd2, 0);

        // Single-flit packet from input 1 moves rr_ptr to 2.
        cycle("single_in1", 0, 5'b00010, 5'b00010, 5'b00000, 0, 5'b00010, 0, 0, 3'd0, 2'd1, 0);
        cycle("refill0",   0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 3'd0, 2'd2, 0);

        // Three-flit packet from input 2 locks the output; input 1 is starved.
        cycle("pkt_head",  0, 5'b00110, 5'b00000, 5'b00000, 0, 5'b00100, 1, 1, 3'd2, 2'd1, 0);
        cycle("pkt_body",  0, 5'b00110, 5'b00000, 5'b00000, 1, 5'b00100, 1, 1, 3'd2, 2'd1, 0);
        cycle("pkt_tail",  0, 5'b00110, 5'b00100, 5'b00000, 1, 5'b00100, 0, 0, 3'd0, 2'd1, 0);

        // rr_ptr is 3: input 4 beats input 1; then pointer wraps to 0 and input 1 wins.
        cycle("rr_in4",    0, 5'b10010, 5'b10010, 5'b00000, 1, 5'b10000, 0, 0, 3'd0, 2'd1, 0);
        cycle("rr_in1",    0, 5'b00010, 5'b00010, 5'b00000, 0, 5'b00010, 0, 0, 3'd0, 2'd0, 0);

        // Zero credits: credit_in does not bypass; grant follows next cycle.
        cycle("zero_cred", 0, 5'b00001, 5'b00001, 5'b00000, 1, 5'b00000, 0, 0, 3'd0, 2'd1, 0);
        cycle("cred_next", 0, 5'b00001, 5'b00001, 5'b00000, 0, 5'b00001, 0, 0, 3'd0, 2'd0, 0);
        cycle("refill1",   0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 3'd0, 2'd1, 0);
        cycle("refill2",   0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 3'd0, 2'd2, 0);

        // Turn mask on input 0: honoured only when the feature is compiled in.
        cycle("mask",      0, 5'b00001, 5'b00001, 5'b00001, 0,
              MASK_EN ? 5'b00000 : 5'b00001, 0, 0, 3'd0, MASK_EN ? 2'd2 : 2'd1, 0);
        cycle("mask_fix",  0, 5'b00000, 5'b00000, 5'b00000, !MASK_EN, 5'b00000, 0, 0, 3'd0, 2'd2, 0);

        // Credit at full count saturates and sets the sticky overflow flag.
        cycle("ovf_set",   0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 3'd0, 2'd2, 1);
        cycle("ovf_hold",  0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 0, 3'd0, 2'd2, 1);

        // Lock on input 3 (rr_ptr is 1), drain credits, then reset mid-packet.
        cycle("lock3_h",   0, 5'b01000, 5'b00000, 5'b00000, 0, 5'b01000, 1, 1, 3'd3, 2'd1, 1);
        cycle("lock3_b",   0, 5'b01000, 5'b00000, 5'b00000, 0, 5'b01000, 1, 1, 3'd3, 2'd0, 1);
        cycle("rst_mid",   1, 5'b01000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 1, 3'd0, 2'd2, 0);

        // After reset: IDLE with rr_ptr 0, so input 0 wins among all requesters.
        cycle("post_rst",  0, 5'b11111, 5'b11111, 5'b00000, 0, 5'b00001, 0, 0, 3'd0, 2'd1, 0);
        cycle("post_cred", 0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 3'd0, 2'd2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wormhole_output_arbiter.md
WORMHOLE_OUTPUT_ARBITER -- requirements
Module: wormhole_output_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 5, number of router input ports competing for this output.
REQ-002 SHALL have parameter FLIT_BUFFER_DEPTH, default 2, downstream buffer depth and initial credit count.
REQ-003 SHALL have localparam CW = $clog2(FLIT_BUFFER_DEPTH+1) and IW = $clog2(NUM_INPUTS).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk_noc, input, 1, the only clock.
REQ-006 SHALL have port rst_noc_sync, input, 1, synchronous active-high reset.
REQ-007 SHALL have port req, input, NUM_INPUTS, bit i high when input i holds a head or body flit routed to this output.
REQ-008 SHALL have port req_is_tail, input, NUM_INPUTS, bit i high when input i's current flit is a tail.
REQ-009 SHALL have port disable_mask, input, NUM_INPUTS, bit i high forbids new packet grants to input i.
REQ-010 SHALL have port credit_in, input, 1, one credit returned by downstream this cycle.
REQ-011 SHALL have port grant, output, NUM_INPUTS, one-hot or zero; flit from the granted input transfers this cycle.
REQ-012 SHALL have port send_out, output, 1, OR-reduction of grant.
REQ-013 SHALL have port locked, output, 1, high while a multi-flit packet owns the output.
REQ-014 SHALL have port lock_owner, output, IW, owning input index, valid while locked.
REQ-015 SHALL have port credit_count, output, CW, current registered credit count.
REQ-016 SHALL have port credit_overflow, output, 1, sticky error flag.

Function
REQ-017 SHALL implement FSM states IDLE and LOCKED.
REQ-018 In IDLE, grant SHALL be combinational, same cycle: the first input i with req[i] && !disable_mask[i], searched from rr_ptr upward with wrap, only if credit_count > 0.
REQ-019 In IDLE, a granted non-tail flit SHALL move the FSM to LOCKED with lock_owner = i; a granted tail flit (single-flit packet) SHALL keep IDLE and set rr_ptr = (i+1) mod NUM_INPUTS.
REQ-020 In LOCKED, grant SHALL go only to lock_owner, when req[owner] && credit_count > 0; disable_mask SHALL NOT interrupt a locked packet.
REQ-021 In LOCKED, a granted tail SHALL return the FSM to IDLE next cycle and set rr_ptr = (owner+1) mod NUM_INPUTS.
REQ-022 credit_count SHALL update to count - send_out + credit_in; simultaneous send and credit leaves it unchanged.
REQ-023 Grant SHALL use only the registered count, with no same-cycle credit_in bypass; count 0 blocks grant even with credit_in high.
REQ-024 credit_in when count == FLIT_BUFFER_DEPTH with no send SHALL saturate the count and set credit_overflow until reset.
REQ-025 rr_ptr SHALL be unchanged when no grant occurs, and SHALL NOT advance on body flits.

Reset
REQ-026 On rst_noc_sync the block SHALL set: state IDLE, rr_ptr 0, lock_owner 0, locked 0, credit_count FLIT_BUFFER_DEPTH, credit_overflow 0.
REQ-027 grant and send_out SHALL be 0 during any cycle with rst_noc_sync high.
REQ-028 Reset mid-packet SHALL abandon the lock without waiting for a tail.

Configuration
REQ-029 Macro ROUTER_ARB_TURN_MASK_EN SHALL control turn masking: when defined, disable_mask is honoured per REQ-018; when undefined, the disable_mask port remains but is ignored (treated as all-zero).

Structure
REQ-030 Package router_arb_pkg SHALL hold the arb_state_e enum (IDLE, LOCKED) and a helper function for width computation.
REQ-031 Combinational sub-module rr_priority_picker (inputs: request vector, pointer; outputs: one-hot grant, index, valid) SHALL perform the rotating search.

Verification
REQ-032 Bench SHALL cover: req=5'b00110, no tails, credits 2 -> grant=00100 (input 2), locked=1, lock_owner=2; input 1 starved until input 2's tail.
REQ-033 Bench SHALL cover: input 2 sends 3 flits (tail on third) with credit_in returned each cycle after a 1-cycle delay -> 3 grants, then IDLE, rr_ptr=3, next grant to input 1 only if no requester in 3..4.
REQ-034 Bench SHALL cover: credits 0 with req[0]=1 and credit_in=1 -> no grant that cycle; grant next cycle, count returns to 0.
REQ-035 Bench SHALL cover: count=2, credit_in=1, no send -> count stays 2, credit_overflow=1 persists until reset.
REQ-036 Bench SHALL cover: with ROUTER_ARB_TURN_MASK_EN defined, disable_mask=00001 and req=00001 -> no grant; undefined -> grant=00001.
REQ-037 Bench SHALL cover: reset asserted while locked on input 3 -> next cycle IDLE, count=FLIT_BUFFER_DEPTH, rr_ptr=0.
